// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, FSM state type and shift-count width.
// Imported by the execute-stage ALU and by the ALU controller.
package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_XOR = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_BNE = 4'b1001,
    OP_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU functions: logic ops, add/sub, signed compare and branch decision.
// Shift codes and unknown codes produce zero here; the iterative shifter lives in the top.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_branch
);

  logic w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result = '0;
    o_branch = 1'b0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      OP_BEQ: begin
        o_result = i_a - i_b;
        o_branch = (i_a == i_b);
      end
      OP_BNE: begin
        o_result = i_a - i_b;
        o_branch = (i_a != i_b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with valid/ready handshake and a one-bit-per-cycle shifter.
// state  | meaning
// IDLE   | ready for a bundle; in_ready high
// SHIFT  | iterating a shift, one bit position per cycle
// DONE   | result presented (out_valid) and held until out_ready
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  BranchTaken
);

  alu_state_e            r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_result, r_shift_val;
  logic [DATA_WIDTH-1:0] w_comb_result, w_imm_result, w_shift_next;
  logic [SHAMT_W-1:0]    r_shift_cnt, w_shamt;
  logic                  r_zero, r_branch, r_shift_left, r_fill;
  logic                  w_comb_branch, w_is_shift, w_start_shift, w_accept, w_last_shift;

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .i_op     (Operation),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_result (w_comb_result),
    .o_branch (w_comb_branch)
  );

  assign w_is_shift    = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign w_shamt       = SrcB[SHAMT_W-1:0];
  assign w_start_shift = w_is_shift && (w_shamt != '0);
  // A zero-distance shift is just a pass-through of SrcA.
  assign w_imm_result  = w_is_shift ? SrcA : w_comb_result;
  assign w_shift_next  = r_shift_left ? {r_shift_val[DATA_WIDTH-2:0], 1'b0}
                                      : {r_fill, r_shift_val[DATA_WIDTH-1:1]};
  assign w_last_shift  = (r_shift_cnt == SHAMT_W'(1));

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign Result      = r_result;
  assign Zero        = r_zero;
  assign BranchTaken = r_branch;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = w_start_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: if (w_last_shift) w_next_state = ST_DONE;
      ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_branch     <= 1'b0;
      r_shift_val  <= '0;
      r_shift_cnt  <= '0;
      r_shift_left <= 1'b0;
      r_fill       <= 1'b0;
    end else if (w_accept && w_start_shift) begin
      r_shift_val  <= SrcA;
      r_shift_cnt  <= w_shamt;
      r_shift_left <= (Operation == OP_SLL);
      r_fill       <= (Operation == OP_SRA) ? SrcA[DATA_WIDTH-1] : 1'b0;
    end else if (w_accept) begin
      r_result <= w_imm_result;
      r_zero   <= (w_imm_result == '0);
      r_branch <= w_comb_branch;
    end else if (r_state == ST_SHIFT) begin
      r_shift_val <= w_shift_next;
      r_shift_cnt <= r_shift_cnt - SHAMT_W'(1);
      if (w_last_shift) begin
        r_result <= w_shift_next;
        r_zero   <= (w_shift_next == '0);
        r_branch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed corner cases plus random bundles
// checked against an arithmetic reference model, with random output back-pressure.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero, BranchTaken;

  ex_alu_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .BranchTaken(BranchTaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        br;
    int          k;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;  // 0 random, 1 forced low, 2 forced high

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic br, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    res = 32'h0;
    br  = 1'b0;
    lat = 1;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0011: res = a - b;
      4'b0110: res = a ^ b;
      4'b0100: res = a << sh;
      4'b0101: res = a >> sh;
      4'b0111: res = $unsigned($signed(a) >>> sh);
      4'b1100: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin res = a - b; br = (a == b); end
      4'b1001: begin res = a - b; br = (a != b); end
      default: ;
    endcase
    if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && sh != 0) lat = sh + 1;
  endfunction

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic br;
    bit   done = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(op, a, b, e.res, br, e.lat);
        e.br   = br;
        e.zero = (e.res == 32'h0);
        e.k    = cyc;
        q.push_back(e);
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Back-pressure driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each new presentation, checks holding while stalled.
  initial begin
    exp_t        e;
    bit          seen = 0;
    bit          expect_low = 0;
    logic [31:0] h_res;
    logic        h_zero, h_br;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        seen = 0;
        expect_low = 0;
      end else begin
        if (expect_low) begin
          chk("out_valid_drop", 32'(out_valid), 32'd0);
          chk("in_ready_after", 32'(in_ready), 32'd1);
          expect_low = 0;
        end
        if (out_valid) begin
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          if (!seen) begin
            if (q.size() == 0) begin
              chk("unexpected_output", 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              chk("result", Result, e.res);
              chk("zero", 32'(Zero), 32'(e.zero));
              chk("branch", 32'(BranchTaken), 32'(e.br));
              chk("latency", 32'(cyc - e.k), 32'(e.lat));
            end
            h_res = Result; h_zero = Zero; h_br = BranchTaken;
            seen = 1;
          end else begin
            chk("hold_result", Result, h_res);
            chk("hold_flags", {30'd0, Zero, BranchTaken}, {30'd0, h_zero, h_br});
          end
          if (out_ready) begin
            seen = 0;
            expect_low = 1;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; Operation = 4'h0; SrcA = 32'h0; SrcB = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_flags", {30'd0, Zero, BranchTaken}, 32'd0);

    ready_mode = 2;
    send(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    send(4'b0011, 32'd5, 32'd5);
    send(4'b1001, 32'd5, 32'd5);
    send(4'b1000, 32'd5, 32'd5);
    send(4'b0111, 32'h80000000, 32'd31);
    send(4'b0101, 32'h80000000, 32'd31);
    send(4'b0100, 32'h00001234, 32'd0);
    send(4'b1100, 32'hFFFFFFFF, 32'd1);
    send(4'b1111, 32'h12345678, 32'h1);
    wait_drain();

    // Held result under five cycles of back-pressure.
    ready_mode = 1;
    send(4'b0110, 32'hA5A5A5A5, 32'h0F0F0F0F);
    wait_drain_start: for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    ready_mode = 2;
    wait_drain();

    // Reset in the middle of a long shift abandons it.
    send(4'b0100, 32'h00000003, 32'd20);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", Result, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    send(4'b0010, 32'd100, 32'd23);
    wait_drain();

    ready_mode = 0;
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'h0;
      send(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_alu_unit.md
EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand and result width; values other than 32 are not supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand bundle present.
REQ-005 in_ready  output  1  unit can accept a bundle this cycle.
REQ-006 Operation  input  4  ALU operation code from the ALU controller.
REQ-007 SrcA  input  DATA_WIDTH  first operand.
REQ-008 SrcB  input  DATA_WIDTH  second operand; SrcB[4:0] is the shift amount for shifts.
REQ-009 out_valid  output  1  Result, Zero and BranchTaken are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Result  output  DATA_WIDTH  registered ALU result.
REQ-012 Zero  output  1  registered (Result == 0).
REQ-013 BranchTaken  output  1  registered branch decision.

Function
REQ-014 Operation encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0111 SRA, 0110 XOR, 1100 SLT (signed), 1000 BEQ, 1001 BNE; any other code gives Result 0 and BranchTaken 0.
REQ-015 ADD/SUB wrap modulo 2^32; no overflow flag.
REQ-016 SLT: Result = 1 if signed(SrcA) < signed(SrcB), else 0.
REQ-017 BEQ/BNE: Result = SrcA - SrcB; BranchTaken = (SrcA == SrcB) for BEQ and (SrcA != SrcB) for BNE.
REQ-018 FSM states: IDLE, SHIFT, DONE.
REQ-019 in_ready = 1 only in IDLE; a bundle is accepted on a rising edge with in_valid && in_ready.
REQ-020 Non-shift op, or shift with shamt 0, accepted in IDLE: result registered, next state DONE (latency 1 cycle).
REQ-021 Shift op with shamt N>0: operand and remaining count latched, next state SHIFT; one bit position is shifted per cycle; after N SHIFT cycles, next state DONE (latency N+1 cycles).
REQ-022 SRA fills with the original SrcA[31]; SRL and SLL fill with 0.
REQ-023 In DONE, out_valid = 1, and Result/Zero/BranchTaken are held stable until out_ready.
REQ-024 DONE with out_ready = 1: next state IDLE, out_valid low the following cycle; no new bundle is accepted in that same cycle.
REQ-025 out_valid = 0 in IDLE and SHIFT; output values are don't-care when out_valid = 0 but retain their last registered value.
REQ-026 Input changes while in SHIFT or DONE are ignored.

Reset
REQ-027 While reset is high at a clock edge: state IDLE, Result 0, Zero 0, BranchTaken 0, out_valid 0, shift count 0.
REQ-028 Reset asserted in SHIFT or DONE abandons the operation; no result is presented afterwards.
REQ-029 The cycle after reset deasserts, in_ready = 1.

Structure
REQ-030 Operation encodings (enum, 4-bit) and the FSM state typedef belong in shared package alu_pkg, imported by this block and the ALU controller.
REQ-031 Single-cycle combinational functions (logic, add/sub, SLT, compare) reside in sub-module alu_comb; the FSM and iterative shifter reside in ex_alu_unit.

Verification
REQ-032 ADD with SrcA=0x7FFFFFFF and SrcB=0x00000001 -> after 1 cycle, Result=0x80000000, Zero=0, out_valid=1.
REQ-033 SUB with SrcA=5 and SrcB=5 -> Result=0, Zero=1; BNE with SrcA=5 and SrcB=5 -> BranchTaken=0; BEQ -> BranchTaken=1.
REQ-034 SRA with SrcA=0x80000000 and SrcB=31 -> out_valid after exactly 32 cycles, Result=0xFFFFFFFF; SRL on the same inputs -> Result=0x00000001.
REQ-035 SLL with shamt 0 and SrcA=0x1234 -> latency 1, Result=0x1234; SLT with SrcA=0xFFFFFFFF and SrcB=1 -> Result=1.
REQ-036 out_ready held low for 5 cycles in DONE -> Result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-037 Reset asserted mid-SHIFT (SLL by 20, at cycle 7) -> next cycle IDLE, out_valid=0, Result=0; a following ADD completes normally.
